// File: rtl/uart_rx_core_if.sv
// Received-word handshake between the UART receiver and its consumer.
// The receiver drives the word, flags and valid; the consumer drives ready.
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 rx_ready;

  modport master (
    output data,
    output data_valid,
    output frame_err,
    output parity_err,
    input  rx_ready
  );

  modport slave (
    input  data,
    input  data_valid,
    input  frame_err,
    input  parity_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with a one-deep output register.
// Framing and parity errors are reported with the word, not dropped.
module uart_rx_core #(
  parameter int OVERSAMPLE = 4,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rxd,
  uart_rx_core_if.master     rx,
  output logic               overrun,
  output logic               busy
);

  localparam logic [5:0] HALF = 6'(OVERSAMPLE / 2 - 1);
  localparam logic [5:0] LAST = 6'(OVERSAMPLE - 1);
  localparam logic [3:0] DLST = 4'(DATA_BITS - 1);
  localparam logic [3:0] SLST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t               st;
  state_t               st_nx;
  logic                 rxd_q;
  logic                 rxd_s;
  logic [5:0]           tick;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr_acc;
  logic                 perr_q;
  logic                 at_last;
  logic                 smp;
  logic                 deliver;
  logic                 par_x;
  logic                 perr_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_q <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_q <= rxd;
      rxd_s <= rxd_q;
    end
  end

  assign at_last = (tick == LAST);
  assign smp     = at_last &&
                   (st == DATA || st == PAR || st == STOP);
  assign par_x   = (^shreg) ^ rxd_s;
  assign perr_nx = (PARITY == 1) ? ~par_x : par_x;

  always_comb begin
    st_nx   = st;
    deliver = 1'b0;
    unique case (st)
      IDLE: begin
        if (!rxd_s) st_nx = START;
      end
      START: begin
        if (tick == HALF) st_nx = rxd_s ? IDLE : DATA;
      end
      DATA: begin
        if (smp && bit_cnt == DLST)
          st_nx = (PARITY != 0) ? PAR : STOP;
      end
      PAR: begin
        if (smp) st_nx = STOP;
      end
      STOP: begin
        if (smp && bit_cnt == SLST) begin
          deliver = 1'b1;
          st_nx   = rxd_s ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (rxd_s) st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      tick     <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      ferr_acc <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      st <= st_nx;
      if (st_nx != st || smp) tick <= '0;
      else if (st != IDLE && st != WAIT_HIGH)
        tick <= tick + 6'd1;
      if (st_nx != st) bit_cnt <= '0;
      else if (smp) bit_cnt <= bit_cnt + 4'd1;
      // Flags restart with every accepted start bit
      if (st == START && st_nx == DATA) begin
        ferr_acc <= 1'b0;
        perr_q   <= 1'b0;
      end
      if (st == DATA && smp)
        shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
      if (st == PAR && smp)
        perr_q <= perr_nx;
      if (st == STOP && smp && !rxd_s)
        ferr_acc <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx.data       <= '0;
      rx.data_valid <= 1'b0;
      rx.frame_err  <= 1'b0;
      rx.parity_err <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      overrun <= deliver && rx.data_valid && !rx.rx_ready;
      if (deliver && (!rx.data_valid || rx.rx_ready)) begin
        rx.data       <= shreg;
        rx.frame_err  <= ferr_acc | ~rxd_s;
        rx.parity_err <= (PARITY != 0) && perr_q;
        rx.data_valid <= 1'b1;
      end else if (rx.data_valid && rx.rx_ready) begin
        rx.data_valid <= 1'b0;
      end
    end
  end

  assign busy = (st != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: 8N1 instance and an even-parity one.
// Drivers push expected words; negedge monitors pop on each accept.
module tb_uart_rx_core;
  localparam int N = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rxd0  = 1'b1;
  logic rxd1  = 1'b1;
  logic ov0, ov1, busy0, busy1;

  uart_rx_core_if #(.DATA_BITS(8)) if0 ();
  uart_rx_core_if #(.DATA_BITS(8)) if1 ();

  uart_rx_core #(
    .OVERSAMPLE(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .rxd(rxd0), .rx(if0.master),
    .overrun(ov0), .busy(busy0)
  );

  uart_rx_core #(
    .OVERSAMPLE(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .rxd(rxd1), .rx(if1.master),
    .overrun(ov1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ov_cnt0 = 0;
  int ov_cnt1 = 0;
  int dv_cyc0 = 0;
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic       held0 = 1'b0;
  logic [9:0] hw0   = '0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor for the 8N1 instance
  always @(negedge clk) begin : mon0
    logic [9:0] w;
    logic [9:0] e;
    if (rst_n) begin
      w = {if0.parity_err, if0.frame_err, if0.data};
      if (ov0) ov_cnt0++;
      if (if0.data_valid) dv_cyc0++;
      if (held0 && if0.data_valid) check("dut0 hold", w, hw0);
      if (if0.data_valid && if0.rx_ready) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut0 unexpected word: got %0h expected none", w);
        end else begin
          e = q0.pop_front();
          check("dut0 word", w, e);
        end
      end
      held0 = if0.data_valid && !if0.rx_ready;
      hw0   = w;
    end else begin
      held0 = 1'b0;
    end
  end

  // Monitor for the even-parity instance
  always @(negedge clk) begin : mon1
    logic [9:0] w;
    logic [9:0] e;
    if (rst_n) begin
      w = {if1.parity_err, if1.frame_err, if1.data};
      if (ov1) ov_cnt1++;
      if (if1.data_valid && if1.rx_ready) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut1 unexpected word: got %0h expected none", w);
        end else begin
          e = q1.pop_front();
          check("dut1 word", w, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bits go out LSB first, each held for one bit period
  task automatic send(input int sel,
                      input logic [15:0] bits,
                      input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) rxd0 = bits[i];
      else          rxd1 = bits[i];
      tick(N);
    end
  endtask

  task automatic frame8(input logic [7:0] b);
    send(0, {6'h3f, 1'b1, b, 1'b0}, 10);
  endtask

  task automatic framep(input logic [7:0] b, input logic p);
    send(1, {5'h1f, 1'b1, p, b, 1'b0}, 11);
  endtask

  initial begin : stim
    int c;
    int lat;
    int bc;
    int d0;
    if0.rx_ready = 1'b1;
    if1.rx_ready = 1'b1;
    tick(3);
    check("rst data", if0.data, 0);
    check("rst flags", {if0.data_valid, if0.frame_err,
                        if0.parity_err, ov0, busy0}, 0);
    check("rst dut1 flags", {if1.data_valid, busy1}, 0);
    rst_n = 1'b1;
    tick(4);

    // 8N1 0x55 with latency and single-cycle valid
    q0.push_back(10'h055);
    dv_cyc0 = 0;
    c = 0;
    fork
      frame8(8'h55);
      begin
        while (!if0.data_valid && c < 100) begin
          tick(1);
          c++;
        end
      end
    join
    lat = c - 2;
    check("latency 38+-1", (lat >= 37 && lat <= 39), 1);
    tick(8);
    check("valid one cycle", dv_cyc0, 1);

    // Even parity: bad and good parity bit
    q1.push_back(10'h2A3);
    framep(8'hA3, 1'b1);
    tick(8);
    q1.push_back(10'h0A3);
    framep(8'hA3, 1'b0);
    tick(8);

    // One-cycle glitch
    d0 = dv_cyc0;
    bc = 0;
    rxd0 = 1'b0;
    tick(1);
    rxd0 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (busy0) bc++;
      tick(1);
    end
    check("glitch busy brief", (bc >= 1 && bc <= 3), 1);
    check("glitch idle", busy0, 0);
    check("glitch no word", dv_cyc0 - d0, 0);

    // Overrun: second word dropped
    if0.rx_ready = 1'b0;
    q0.push_back(10'h011);
    frame8(8'h11);
    tick(8);
    frame8(8'h22);
    tick(8);
    check("overrun once", ov_cnt0, 1);
    check("held word", if0.data, 8'h11);
    if0.rx_ready = 1'b1;
    tick(4);

    // Break: one framing-error word, busy until line high
    q0.push_back(10'h100);
    rxd0 = 1'b0;
    tick(120);
    check("break busy", busy0, 1);
    rxd0 = 1'b1;
    tick(6);
    check("break released", busy0, 0);
    tick(4);

    // Reset mid-frame, then a clean frame
    send(0, {6'h3f, 1'b1, 8'h3C, 1'b0}, 6);
    rst_n = 1'b0;
    rxd0  = 1'b1;
    tick(1);
    check("midrst outputs", {if0.data_valid, busy0, ov0}, 0);
    check("midrst data", if0.data, 0);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    check("midrst no word", {if0.data_valid, busy0}, 0);
    q0.push_back(10'h03C);
    frame8(8'h3C);
    tick(8);

    c = 0;
    while ((q0.size() + q1.size()) != 0 && c < 200) begin
      tick(1);
      c++;
    end
    check("queues drained", q0.size() + q1.size(), 0);
    check("overrun total", ov_cnt0, 1);
    check("dut1 no overrun", ov_cnt1, 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
